// File: rtl/servo_ramp_pkg.sv
// Shared register map, widths and helpers for the wb_servo_ramp servo controller.
package servo_ramp_pkg;

    localparam int W_US   = 12;
    localparam int W_STEP = 8;
    localparam int N_CH   = 8;

    localparam logic [4:0] REG_TARGET0  = 5'd0;
    localparam logic [4:0] REG_STEP     = 5'd8;
    localparam logic [4:0] REG_ENABLE   = 5'd9;
    localparam logic [4:0] REG_STATUS   = 5'd10;
    localparam logic [4:0] REG_CURRENT0 = 5'd16;

    // Limit a written pulse width to the mechanically safe servo range.
    function automatic logic [W_US-1:0] clamp_us(input logic [15:0] v, input int lo, input int hi);
        logic [W_US-1:0] r;
        if (v < 16'(lo))
            r = W_US'(lo);
        else if (v > 16'(hi))
            r = W_US'(hi);
        else
            r = v[W_US-1:0];
        return r;
    endfunction

endpackage

// File: rtl/servo_ramp_channel.sv
// One servo channel: clamped target register, per-frame saturating slew of the
// current width, and the registered PWM compare against the frame counter.
module servo_ramp_channel
    import servo_ramp_pkg::*;
#(
    parameter int CNT_W     = 15,
    parameter int min_us    = 500,
    parameter int max_us    = 2500,
    parameter int center_us = 1500
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [1:0]        wr_sel,
    input  logic [15:0]       wr_data,
    input  logic              frame_start,
    input  logic [W_STEP-1:0] step,
    input  logic              en,
    input  logic [CNT_W-1:0]  us_cnt,
    output logic [W_US-1:0]   target,
    output logic [W_US-1:0]   current,
    output logic              busy,
    output logic              servo
);

    logic [15:0]   wr_merged;
    logic [W_US:0] cur_x;
    logic [W_US:0] tgt_x;
    logic [W_US:0] stp_x;
    logic [W_US:0] diff;
    logic [W_US-1:0] current_nxt;

    assign wr_merged = {wr_sel[1] ? wr_data[15:8] : 8'(target[W_US-1:8]),
                        wr_sel[0] ? wr_data[7:0]  : target[7:0]};

    assign cur_x = {1'b0, current};
    assign tgt_x = {1'b0, target};
    assign stp_x = (W_US+1)'(step);

    // Compare the remaining distance with the step so the result never overshoots.
    always_comb begin
        current_nxt = current;
        diff        = '0;
        if (step == '0) begin
            current_nxt = target;
        end else if (current < target) begin
            diff        = tgt_x - cur_x;
            current_nxt = (diff <= stp_x) ? target : W_US'(cur_x + stp_x);
        end else if (current > target) begin
            diff        = cur_x - tgt_x;
            current_nxt = (diff <= stp_x) ? target : W_US'(cur_x - stp_x);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target  <= W_US'(center_us);
            current <= W_US'(center_us);
            servo   <= 1'b0;
        end else begin
            if (wr_en)
                target <= clamp_us(wr_merged, min_us, max_us);
            if (frame_start)
                current <= current_nxt;
            servo <= en & (32'(us_cnt) < 32'(current));
        end
    end

    assign busy = (current != target);

endmodule

// File: rtl/wb_servo_ramp.sv
// Wishbone eight-channel servo PWM with per-frame slew limiting.
// Define WB_SERVO_RAMP_IRQ_EN to build the settle interrupt (intr, STATUS bit 8).
module wb_servo_ramp
    import servo_ramp_pkg::*;
#(
    parameter int clk_freq  = 100000000,
    parameter int frame_us  = 20000,
    parameter int min_us    = 500,
    parameter int max_us    = 2500,
    parameter int center_us = 1500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    input  logic        wb_we_i,
    output logic        wb_ack_o,
    output logic        intr,
    output logic [7:0]  servo
);

    localparam int DIV   = clk_freq / 1000000;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CNT_W = (frame_us > 1) ? $clog2(frame_us) : 1;

    logic [PRE_W-1:0]  pre;
    logic [CNT_W-1:0]  us_cnt;
    logic              us_tick;
    logic              frame_start;
    logic [4:0]        idx;
    logic              acc;
    logic              wr;
    logic [31:0]       rd_data;
    logic [W_STEP-1:0] step_q;
    logic [N_CH-1:0]   enable_q;
    logic [N_CH-1:0]   busy;
    logic [W_US-1:0]   target_w  [N_CH];
    logic [W_US-1:0]   current_w [N_CH];
    logic              unused_bits;

    assign unused_bits = ^{wb_adr_i[31:7], wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

    assign idx         = wb_adr_i[6:2];
    assign acc         = wb_stb_i & wb_cyc_i & ~wb_ack_o;
    assign wr          = acc & wb_we_i;
    assign us_tick     = (pre == PRE_W'(DIV - 1));
    assign frame_start = us_tick & (us_cnt == CNT_W'(frame_us - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre    <= '0;
            us_cnt <= '0;
        end else if (us_tick) begin
            pre    <= '0;
            us_cnt <= (us_cnt == CNT_W'(frame_us - 1)) ? '0 : us_cnt + CNT_W'(1);
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        servo_ramp_channel #(
            .CNT_W     (CNT_W),
            .min_us    (min_us),
            .max_us    (max_us),
            .center_us (center_us)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .wr_en       (wr && idx[4:3] == REG_TARGET0[4:3] && idx[2:0] == 3'(g) && |wb_sel_i[1:0]),
            .wr_sel      (wb_sel_i[1:0]),
            .wr_data     (wb_dat_i[15:0]),
            .frame_start (frame_start),
            .step        (step_q),
            .en          (enable_q[g]),
            .us_cnt      (us_cnt),
            .target      (target_w[g]),
            .current     (current_w[g]),
            .busy        (busy[g]),
            .servo       (servo[g])
        );
    end

    always_comb begin
        rd_data = '0;
        if (idx[4:3] == REG_TARGET0[4:3]) begin
            rd_data = 32'(target_w[idx[2:0]]);
        end else if (idx[4:3] == REG_CURRENT0[4:3]) begin
            rd_data = 32'(current_w[idx[2:0]]);
        end else begin
            case (idx)
                REG_STEP:   rd_data = 32'(step_q);
                REG_ENABLE: rd_data = 32'(enable_q);
                REG_STATUS: rd_data = {23'b0, intr, busy};
                default:    rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            step_q   <= '0;
            enable_q <= '0;
        end else begin
            wb_ack_o <= acc;
            if (acc)
                wb_dat_o <= rd_data;
            if (wr && idx == REG_STEP && wb_sel_i[0])
                step_q <= wb_dat_i[W_STEP-1:0];
            if (wr && idx == REG_ENABLE && wb_sel_i[0])
                enable_q <= wb_dat_i[N_CH-1:0];
        end
    end

`ifdef WB_SERVO_RAMP_IRQ_EN
    logic settled;
    logic slew_d;
    logic irq_clr;

    assign irq_clr = wr && idx == REG_STATUS && wb_sel_i[1] && wb_dat_i[8];

    // Only a slew can complete a settle; target writes that cancel busy never interrupt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settled <= 1'b0;
            slew_d  <= 1'b0;
            intr    <= 1'b0;
        end else begin
            slew_d  <= frame_start;
            settled <= (busy == '0);
            if (slew_d && !settled && busy == '0)
                intr <= 1'b1;
            else if (irq_clr)
                intr <= 1'b0;
        end
    end
`else
    assign intr = 1'b0;
`endif

endmodule
